val_stream_mul: RTL
===================

Name: val_stream_mul

Overview:
- Two-input streaming multiply stage that sits directly upstream of the reg_cr reducer in the sparse pipeline.
- Joins two aligned 17-bit value streams (A, B) from intersect or repeat outputs.
- Emits per-element products and passes stop/done tokens through, so the reducer can accumulate per fiber.
- Valid/ready on every port; 2-stage pipeline with full backpressure.

Parameters:
DATA_W, 16, payload width; stream word is DATA_W+1 bits, MSB = token flag
DONE_CODE, 16'h0100, payload of the done token (word 17'h10100)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
clk_en  in  1  global enable; 0 freezes all state
flush  in  1  synchronous clear of pipeline and FSM
tile_en  in  1  0: block inert, all ready/valid outputs low
a_in  in  17  stream A word
a_in_valid  in  1  A valid
a_in_ready  out  1  A ready
b_in  in  17  stream B word
b_in_valid  in  1  B valid
b_in_ready  out  1  B ready
data_out  out  17  product/token stream to reducer
data_out_valid  out  1  output valid
data_out_ready  in  1  downstream ready
align_err  out  1  sticky token-misalignment flag

Behaviour:
- Reset (rst=1, async): both stage valids 0, FSM=RUN, align_err=0, data_out=0, data_out_valid=0. Ready outputs are 0 while reset is held.
- Word decode:
  - bit16=0: data.
  - bit16=1 and payload==DONE_CODE: done token.
  - Otherwise bit16=1 is a stop token, level = payload[7:0].
- Join: one element from each input is consumed only in a cycle where all of the following hold:
  - a_in_valid and b_in_valid are both 1;
  - s1_advance=1;
  - FSM=RUN, tile_en=1, clk_en=1.
  - a_in_ready = b_in_ready = s1_advance & b_in_valid/a_in_valid respectively. Each input's ready requires the other input's valid, so neither input is consumed alone.
- Stage 1 register (S1) captures the joined pair and its class.
- Stage 2 register (S2) drives data_out.
- Advance rules:
  - s2_advance = !S2.valid | data_out_ready.
  - s1_advance = !S1.valid | s2_advance.
- Latency: 2 cycles from join to data_out_valid when unstalled. Throughput is 1 word/cycle. Holding data_out_ready=0 stalls both stages with no loss or duplication.
- Output word:
  - data/data: {0, (A*B) mod 2^16}, unsigned, low 16 bits kept.
  - stop/stop, equal level: A word unchanged.
  - done/done: 17'h10100.
  - Any other pairing (data vs token, unequal stop levels, done vs non-done): A word passes, align_err set to 1 (sticky until rst/flush).
- FSM:
  - RUN -> DONE when the done/done pair is joined.
  - DONE: input readies held 0. The pipeline drains, so the done word is still emitted.
  - DONE -> RUN only on flush or rst.
  - A done vs non-done mismatch also enters DONE.
- Output holding: data_out/data_out_valid hold stable while valid=1 and ready=0. Valid is never retracted without a handshake, except on rst/flush.
- flush (synchronous, sampled at clk edge when clk_en=1): clears S1/S2 valids, FSM=RUN, align_err=0. flush has priority over join in the same cycle.
- tile_en=0: readies and data_out_valid forced 0; internal registers retain value.
- clk_en=0: no state change, outputs hold.
- Reset mid-stream: in-flight words are discarded. After deassert, the block accepts a fresh stream.

Test Plan:
1. A=[3,4,stop0,done], B=[5,6,stop0,done], out always ready -> out=[0x000F,0x0018,0x10000,0x10100]. First valid 2 cycles after first join. align_err=0.
2. Overflow: A=0xFFFF, B=0x0002 -> out 0x0FFFE. A=0x0100, B=0x0100 -> out 0x00000.
3. Backpressure: same streams as test 1. data_out_ready toggles 1,0,0,1 repeating -> identical output sequence, no duplicates. data_out held stable during stalls. Input readies drop when both stages are full.
4. Skew: B valid 3 cycles after A each element -> no A consumption before B valid. Output equals test 1.
5. Mismatch: A=[7,stop1], B=[2,stop0] -> out=[0x000E,0x10001]. align_err=1 and stays 1 until flush.
6. After done: inputs remain valid but readies stay 0. Pulse flush -> FSM RUN, align_err=0, new stream A=[2,done], B=[9,done] -> [0x0012,0x10100]. Assert rst mid-stream -> data_out_valid=0 immediately (async).

Source files
------------

// File: rtl/val_stream_mul_if.sv
`default_nettype none
// ============================================================================
// Module   : val_stream_mul_if
// Purpose  : Valid/ready bundle for the two value inputs and the product output.
// Revision : 1.0
// ============================================================================
interface val_stream_mul_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W:0] a_in;
    logic            a_in_valid;
    logic            a_in_ready;
    logic [DATA_W:0] b_in;
    logic            b_in_valid;
    logic            b_in_ready;
    logic [DATA_W:0] data_out;
    logic            data_out_valid;
    logic            data_out_ready;

    // Upstream producers and downstream consumer.
    modport master (
        output a_in, a_in_valid,
        input  a_in_ready,
        output b_in, b_in_valid,
        input  b_in_ready,
        input  data_out, data_out_valid,
        output data_out_ready
    );

    // The multiply stage itself.
    modport slave (
        input  a_in, a_in_valid,
        output a_in_ready,
        input  b_in, b_in_valid,
        output b_in_ready,
        output data_out, data_out_valid,
        input  data_out_ready
    );
endinterface
`default_nettype wire

// File: rtl/val_stream_mul.sv
`default_nettype none
// ============================================================================
// Module   : val_stream_mul
// Purpose  : Joins two aligned value streams, multiplies data pairs and passes
//            stop/done tokens through a 2-stage valid/ready pipeline.
// Revision : 1.0
// ============================================================================
module val_stream_mul #(
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] DONE_CODE = 16'h0100
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       clk_en,
    input  wire logic       flush,
    input  wire logic       tile_en,
    val_stream_mul_if.slave sif,
    output logic            align_err
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_s1_valid;
    logic [DATA_W:0]   r_s1_a;
    logic [DATA_W:0]   r_s1_b;
    logic              r_s2_valid;
    logic [DATA_W:0]   r_s2_word;
    logic              r_align_err;

    logic              w_s1_adv;
    logic              w_s2_adv;
    logic              w_accept;
    logic              w_join;
    logic              w_in_done;
    logic              w_pair_ok;
    logic [DATA_W-1:0] w_prod;
    logic [DATA_W:0]   w_result;

    function automatic logic f_is_done(input logic [DATA_W:0] w);
        return w[DATA_W] && (w[DATA_W-1:0] == DONE_CODE);
    endfunction

    function automatic logic f_is_stop(input logic [DATA_W:0] w);
        return w[DATA_W] && !f_is_done(w);
    endfunction

    // A pair is aligned when both sides carry the same kind of word
    // and, for stop tokens, the same level.
    function automatic logic f_pair_ok(input logic [DATA_W:0] a, input logic [DATA_W:0] b);
        logic ok;
        ok = 1'b0;
        if (!a[DATA_W] && !b[DATA_W]) begin
            ok = 1'b1;
        end else if (f_is_done(a) && f_is_done(b)) begin
            ok = 1'b1;
        end else if (f_is_stop(a) && f_is_stop(b) && (a[7:0] == b[7:0])) begin
            ok = 1'b1;
        end
        return ok;
    endfunction

    // ------------------------------------------------------------------
    // Handshake: a pair is taken only when both sides are valid together
    // ------------------------------------------------------------------
    assign w_s2_adv = !r_s2_valid || sif.data_out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_accept = (r_state == ST_RUN) && tile_en && clk_en && !flush && !rst && w_s1_adv;

    assign sif.a_in_ready = w_accept && sif.b_in_valid;
    assign sif.b_in_ready = w_accept && sif.a_in_valid;
    assign w_join         = sif.a_in_ready && sif.a_in_valid;

    assign w_in_done = f_is_done(sif.a_in) || f_is_done(sif.b_in);
    assign w_pair_ok = f_pair_ok(sif.a_in, sif.b_in);

    assign sif.data_out       = r_s2_word;
    assign sif.data_out_valid = r_s2_valid && tile_en;
    assign align_err          = r_align_err;

    // ------------------------------------------------------------------
    // Result formation for the pair held in stage 1
    // ------------------------------------------------------------------
    always_comb begin
        w_prod   = r_s1_a[DATA_W-1:0] * r_s1_b[DATA_W-1:0];
        w_result = r_s1_a;
        if (!r_s1_a[DATA_W] && !r_s1_b[DATA_W]) begin
            w_result = {1'b0, w_prod};
        end else if (f_is_done(r_s1_a) && f_is_done(r_s1_b)) begin
            w_result = {1'b1, DONE_CODE};
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: any joined pair carrying a done token ends the run
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_RUN;
        end else if (w_join && w_in_done) begin
            w_state_nxt = ST_DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else if (clk_en) begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline stages; tile_en=0 freezes them without losing contents
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_word   <= '0;
            r_align_err <= 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                r_s1_valid  <= 1'b0;
                r_s2_valid  <= 1'b0;
                r_align_err <= 1'b0;
            end else if (tile_en) begin
                if (w_s1_adv) begin
                    r_s1_valid <= w_join;
                    if (w_join) begin
                        r_s1_a <= sif.a_in;
                        r_s1_b <= sif.b_in;
                    end
                end
                if (w_s2_adv) begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_s2_word <= w_result;
                    end
                end
                if (w_join && !w_pair_ok) begin
                    r_align_err <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
